// File: rtl/ssb_dac_out.sv
// SSB DAC output stage: rounds and clips the modulator product to an offset-binary code,
// supervised by an IDLE/SETTLE/RUN/FAULT machine with per-window clip and peak monitoring.
module ssb_dac_out #(
  parameter int SHIFT      = 35,
  parameter int DAC_W      = 14,
  parameter int SETTLE_CYC = 4096,
  parameter int WIN        = 1024,
  parameter int SAT_MAX    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [63:0]      result,
  input  logic             result_vld,
  input  logic             clr_fault,
  output logic [DAC_W-1:0] dac_data,
  output logic             dac_vld,
  output logic             sat_flag,
  output logic [15:0]      sat_cnt,
  output logic [DAC_W-2:0] peak,
  output logic [1:0]       state
);
  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, RUN = 2'd2, FAULT = 2'd3} state_t;

  localparam int S1W = 65 - SHIFT;
  localparam int SCW = $clog2(SETTLE_CYC + 1);
  localparam int WCW = $clog2(WIN + 1);
  localparam int CCW = $clog2(SAT_MAX + 1);
  localparam logic signed [S1W-1:0] VMAX = S1W'((2 ** (DAC_W - 1)) - 1);
  localparam logic signed [S1W-1:0] VMIN = S1W'(-(2 ** (DAC_W - 1)));
  localparam logic [DAC_W-1:0]      MID  = {1'b1, {(DAC_W - 1){1'b0}}};

  state_t                st, nxt;
  logic [3:1]            vld_pipe;
  logic signed [S1W-1:0] rnd, s1;
  logic [DAC_W-1:0]      clip_val, s2_val, neg_val;
  logic                  clip_hit, s2_clip;
  logic [DAC_W-2:0]      abs_val, run_peak, peak_upd;
  logic [SCW-1:0]        settle_cnt;
  logic [WCW-1:0]        win_cnt;
  logic [CCW-1:0]        win_clip;
  logic                  run_smp, fault_hit, wrap, settle_done;
  logic                  unused_lsb;

  // Adding half an LSB then shifting equals the floor quotient plus the first dropped bit,
  // so only the kept bits and result[SHIFT-1] matter; the rest cannot change the outcome.
  assign rnd        = $signed({result[63], result[63:SHIFT]}) + S1W'(result[SHIFT-1]);
  assign unused_lsb = ^result[SHIFT-2:0];

  always_comb begin
    clip_val = s1[DAC_W-1:0];
    clip_hit = 1'b0;
    if (s1 > VMAX) begin
      clip_val = VMAX[DAC_W-1:0];
      clip_hit = 1'b1;
    end else if (s1 < VMIN) begin
      clip_val = VMIN[DAC_W-1:0];
      clip_hit = 1'b1;
    end
  end

  // Magnitude of the most negative code does not fit, so it reports as full scale.
  assign neg_val  = ~s2_val + DAC_W'(1);
  assign abs_val  = !s2_val[DAC_W-1] ? s2_val[DAC_W-2:0] :
                    (neg_val[DAC_W-1] ? '1 : neg_val[DAC_W-2:0]);
  assign peak_upd = (abs_val > run_peak) ? abs_val : run_peak;

  assign run_smp     = vld_pipe[2] && en && (st == RUN);
  assign fault_hit   = run_smp && s2_clip && (win_clip == CCW'(SAT_MAX - 1));
  assign wrap        = run_smp && (win_cnt == WCW'(WIN - 1));
  assign settle_done = vld_pipe[2] && en && (st == SETTLE) &&
                       (settle_cnt == SCW'(SETTLE_CYC - 1));

  always_comb begin
    nxt = st;
    case (st)
      IDLE:    if (en) nxt = SETTLE;
      SETTLE:  if (!en) nxt = IDLE; else if (settle_done) nxt = RUN;
      RUN:     if (!en) nxt = IDLE; else if (fault_hit) nxt = FAULT;
      FAULT:   if (clr_fault) nxt = en ? SETTLE : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st         <= IDLE;
      vld_pipe   <= '0;
      s1         <= '0;
      s2_val     <= '0;
      s2_clip    <= 1'b0;
      dac_data   <= MID;
      sat_flag   <= 1'b0;
      sat_cnt    <= '0;
      peak       <= '0;
      settle_cnt <= '0;
      win_cnt    <= '0;
      win_clip   <= '0;
      run_peak   <= '0;
    end else begin
      st       <= nxt;
      vld_pipe <= {vld_pipe[2:1], result_vld};
      if (result_vld) s1 <= rnd;
      if (vld_pipe[1]) begin
        s2_val  <= clip_val;
        s2_clip <= clip_hit;
      end
      // The fault decision is made on this same edge, so the triggering sample is muted.
      if (vld_pipe[2]) begin
        dac_data <= (run_smp && !fault_hit) ? {~s2_val[DAC_W-1], s2_val[DAC_W-2:0]} : MID;
        sat_flag <= s2_clip;
      end
      if (clr_fault) sat_cnt <= '0;
      else if (vld_pipe[2] && s2_clip && st != IDLE && sat_cnt != 16'hFFFF)
        sat_cnt <= sat_cnt + 16'd1;
      if (st != SETTLE) settle_cnt <= '0;
      else if (vld_pipe[2] && en) settle_cnt <= settle_cnt + SCW'(1);
      if (st != RUN || wrap) begin
        win_cnt  <= '0;
        win_clip <= '0;
        run_peak <= '0;
      end else if (run_smp) begin
        win_cnt  <= win_cnt + WCW'(1);
        win_clip <= win_clip + CCW'(s2_clip);
        run_peak <= peak_upd;
      end
      if (wrap) peak <= peak_upd;
    end
  end

  assign dac_vld = vld_pipe[3];
  assign state   = st;
endmodule

// File: tb/tb_ssb_dac_out.sv
// Randomized bench for ssb_dac_out: an arithmetic reference model is compared every cycle,
// with literal expectations pinning rounding, clipping, settle, fault, peak and reset.
module tb_ssb_dac_out;
  localparam int SHIFT = 35, DAC_W = 14, SETTLE_CYC = 4096, WIN = 1024, SAT_MAX = 16;
  localparam int IDLE = 0, SETTLE = 1, RUN = 2, FAULT = 3;
  localparam int QMAX = 2 ** (DAC_W - 1) - 1;
  localparam int MIDC = 2 ** (DAC_W - 1);

  logic clk = 0, rst = 0, en = 0, result_vld = 0, clr_fault = 0;
  logic [63:0] result = '0;
  logic [DAC_W-1:0] dac_data;
  logic dac_vld, sat_flag;
  logic [15:0] sat_cnt;
  logic [DAC_W-2:0] peak;
  logic [1:0] state;
  int n_chk = 0, n_fail = 0;
  bit chk_on = 0;

  always #5 clk = ~clk;

  ssb_dac_out #(.SHIFT(SHIFT), .DAC_W(DAC_W), .SETTLE_CYC(SETTLE_CYC), .WIN(WIN),
                .SAT_MAX(SAT_MAX)) dut (
    .clk(clk), .rst(rst), .en(en), .result(result), .result_vld(result_vld),
    .clr_fault(clr_fault), .dac_data(dac_data), .dac_vld(dac_vld), .sat_flag(sat_flag),
    .sat_cnt(sat_cnt), .peak(peak), .state(state));

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Round half up then clip, done in wide arithmetic.
  function automatic int quantize(logic [63:0] r, output bit clipped);
    logic signed [127:0] w;
    w = $signed({{64{r[63]}}, r});
    w = (w + (128'sd1 <<< (SHIFT - 1))) >>> SHIFT;
    clipped = 1'b1;
    if (w > QMAX) return QMAX;
    if (w < -QMAX - 1) return -QMAX - 1;
    clipped = 1'b0;
    return int'(w);
  endfunction

  int m_st = 0, m_sat = 0, m_peak = 0, m_settle = 0, m_wcnt = 0, m_wclip = 0, m_wpeak = 0;
  int exp_data = MIDC;
  bit exp_vld = 0, exp_flag = 0;
  bit h1v = 0, h2v = 0;
  logic [63:0] h1r = '0, h2r = '0;

  // Model: the sample taken two edges ago is judged with the present en/clr_fault.
  always @(posedge clk or negedge rst) begin : model
    int c, a, nst, settle, wcnt, wclip, wpeak, pk, sat;
    bit cl, run, flt;
    if (!rst) begin
      m_st <= IDLE; m_sat <= 0; m_peak <= 0; m_settle <= 0;
      m_wcnt <= 0; m_wclip <= 0; m_wpeak <= 0;
      exp_vld <= 0; exp_flag <= 0; exp_data <= MIDC;
      h1v <= 0; h2v <= 0; h1r <= '0; h2r <= '0;
    end else begin
      c = quantize(h2r, cl);
      a = (c < 0) ? ((c == -QMAX - 1) ? QMAX : -c) : c;
      nst = m_st; settle = m_settle; wcnt = m_wcnt; wclip = m_wclip;
      wpeak = m_wpeak; pk = m_peak; sat = m_sat; flt = 0;
      run = h2v && en && (m_st == RUN);
      if (clr_fault) sat = 0;
      else if (h2v && cl && m_st != IDLE && sat < 65535) sat++;
      case (m_st)
        IDLE:   if (en) nst = SETTLE;
        SETTLE: if (!en) nst = IDLE;
                else if (h2v) begin
                  settle++;
                  if (settle == SETTLE_CYC) nst = RUN;
                end
        RUN:    if (!en) nst = IDLE;
                else if (h2v) begin
                  wcnt++;
                  wclip += int'(cl);
                  if (a > wpeak) wpeak = a;
                  if (wclip == SAT_MAX) begin flt = 1; nst = FAULT; end
                  if (wcnt == WIN) begin pk = wpeak; wcnt = 0; wclip = 0; wpeak = 0; end
                end
        FAULT:  if (clr_fault) nst = en ? SETTLE : IDLE;
        default: nst = IDLE;
      endcase
      if (nst != m_st) begin settle = 0; wcnt = 0; wclip = 0; wpeak = 0; end
      exp_vld <= h2v;
      if (h2v) begin
        exp_data <= (run && !flt) ? c + MIDC : MIDC;
        exp_flag <= cl;
      end
      m_st <= nst; m_sat <= sat; m_peak <= pk; m_settle <= settle;
      m_wcnt <= wcnt; m_wclip <= wclip; m_wpeak <= wpeak;
      h2v <= h1v; h2r <= h1r; h1v <= result_vld; h1r <= result;
    end
  end

  always @(negedge clk) begin
    if (rst && chk_on) begin
      chk("state", 64'(state), 64'(m_st));
      chk("sat_cnt", 64'(sat_cnt), 64'(m_sat));
      chk("peak", 64'(peak), 64'(m_peak));
      chk("dac_vld", 64'(dac_vld), 64'(exp_vld));
      if (exp_vld) begin
        chk("dac_data", 64'(dac_data), 64'(exp_data));
        chk("sat_flag", 64'(sat_flag), 64'(exp_flag));
      end
    end
  end

  task automatic send(bit v, logic [63:0] r, bit c = 1'b0);
    @(negedge clk);
    result_vld = v; result = r; clr_fault = c;
  endtask

  task automatic idle(int n);
    repeat (n) send(1'b0, {$urandom, $urandom});
  endtask

  function automatic logic [63:0] sc(longint k);
    return 64'(k <<< SHIFT);
  endfunction

  function automatic logic [63:0] rnd_val(int lim, bit wild);
    longint k;
    logic [34:0] lo;
    if (wild && $urandom_range(7) == 0) return {$urandom, $urandom};
    k  = longint'($urandom_range(2 * lim)) - longint'(lim);
    lo = {3'($urandom_range(7)), $urandom};
    return sc(k) + 64'(lo);
  endfunction

  // One isolated sample: output must be absent after two cycles and present after three.
  task automatic one(string name, logic [63:0] r, logic [DAC_W-1:0] exp, bit flag);
    send(1'b1, r);
    send(1'b0, '0);
    send(1'b0, '0);
    chk({name, "_early"}, 64'(dac_vld), 64'(0));
    @(negedge clk);
    chk({name, "_vld"}, 64'(dac_vld), 64'(1));
    chk({name, "_data"}, 64'(dac_data), 64'(exp));
    chk({name, "_flag"}, 64'(sat_flag), 64'(flag));
  endtask

  task automatic reset_vals(string name);
    chk({name, "_state"}, 64'(state), 64'(0));
    chk({name, "_data"}, 64'(dac_data), 64'(14'h2000));
    chk({name, "_vld"}, 64'(dac_vld), 64'(0));
    chk({name, "_flag"}, 64'(sat_flag), 64'(0));
    chk({name, "_satcnt"}, 64'(sat_cnt), 64'(0));
    chk({name, "_peak"}, 64'(peak), 64'(0));
  endtask

  initial begin
    int pos, snap, s0;
    #12;
    reset_vals("rst");
    @(negedge clk);
    rst = 1; chk_on = 1; en = 1;

    repeat (SETTLE_CYC) send(1'b1, rnd_val(9000, 1'b1));
    idle(3);
    one("three", sc(3), 14'h2003, 1'b0);
    chk("run_state", 64'(state), 64'(RUN));
    one("half_up", 64'h0000_0004_0000_0000, 14'h2001, 1'b0);
    one("half_neg", 64'hFFFF_FFFC_0000_0000, 14'h2000, 1'b0);
    s0 = m_sat;
    one("pos_sat", 64'h7FFF_FFFF_FFFF_FFFF, 14'h3FFF, 1'b1);
    chk("pos_sat_cnt", 64'(sat_cnt), 64'(s0 + 1));
    one("neg_sat", 64'h8000_0000_0000_0000, 14'h0000, 1'b1);
    chk("neg_sat_cnt", 64'(sat_cnt), 64'(s0 + 2));

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3) == 0) send(1'b0, {$urandom, $urandom}, $urandom_range(99) == 0);
      else send(1'b1, rnd_val(8250, 1'b0), $urandom_range(99) == 0);
    end

    idle(3);
    send(1'b0, '0, 1'b1);
    en = 0;
    send(1'b0, '0);
    chk("en_low_idle", 64'(state), 64'(IDLE));
    en = 1;
    repeat (SETTLE_CYC) send(1'b1, rnd_val(8000, 1'b1));

    snap = m_peak;
    pos  = $urandom_range(WIN - 1);
    for (int i = 0; i < WIN - 1; i++) begin
      if ($urandom_range(4) == 0) idle(1);
      send(1'b1, (i == pos) ? sc(5000) : rnd_val(4998, 1'b0));
    end
    idle(3);
    chk("peak_hold", 64'(peak), 64'(snap));
    chk("peak_run", 64'(state), 64'(RUN));
    send(1'b1, (pos == WIN - 1) ? sc(5000) : rnd_val(4998, 1'b0));
    idle(3);
    chk("peak_wrap", 64'(peak), 64'(5000));

    for (int i = 0; i < SAT_MAX; i++)
      send(1'b1, i[0] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF);
    idle(2);
    @(negedge clk);
    chk("fault_state", 64'(state), 64'(FAULT));
    chk("fault_mute", 64'(dac_data), 64'(14'h2000));
    chk("fault_flag", 64'(sat_flag), 64'(1));
    send(1'b0, '0, 1'b1);
    send(1'b0, '0);
    chk("clr_state", 64'(state), 64'(SETTLE));
    chk("clr_satcnt", 64'(sat_cnt), 64'(0));

    repeat (SETTLE_CYC) send(1'b1, rnd_val(8000, 1'b0));
    repeat (20) send(1'($urandom_range(1)), rnd_val(8000, 1'b0));
    chk("pre_rst_run", 64'(state), 64'(RUN));
    @(posedge clk);
    #2;
    rst = 0; result_vld = ~result_vld;
    #1;
    reset_vals("mid_rst");
    repeat (4) send(1'($urandom_range(1)), rnd_val(8000, 1'b1));
    reset_vals("held_rst");
    @(negedge clk);
    rst = 1;
    repeat (40) send(1'($urandom_range(1)), rnd_val(9000, 1'b1));
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
